burst_memory: RTL and testbench
===============================

// Module: burst_memory
//
// PURPOSE
//   Byte-addressed, big-endian unified memory for the MIPS pipeline. It extends the
//   single-word memory with parametrised depth and base address, and adds
//   byte/half/word sub-word access with sign/zero extension. It also adds 4/8/16-beat
//   read and write bursts and address-range/alignment error reporting.
//   Serves the fetch stage (read bursts) and the memory stage (single
//   loads/stores, with writeback bypass).
//
// PARAMETERS
//   DEPTH_BYTES  1048576       memory size in bytes (power of two)
//   BASE_ADDR    32'h80020000  address mapped to byte offset 0
//
// PORTS
//   clock         in   1   rising-edge clock
//   reset         in   1   synchronous, active-high reset
//   enable        in   1   request strobe; accepted only when busy==0
//   rw            in   1   1 = read, 0 = write
//   address       in   32  byte address of first beat
//   data_in       in   32  write data (beat 0 at accept; later beats while busy)
//   access_size   in   2   00 = single, 01 = 4-beat, 10 = 8-beat, 11 = 16-beat burst
//   dm_size       in   2   00 = word, 01 = half, 10 = byte, 11 = reserved (treated as word)
//   sign_ext      in   1   1 = sign-extend sub-word reads, 0 = zero-extend
//   wm_bypass     in   32  forwarded store data from writeback
//   do_wm_bypass  in   1   1 = use wm_bypass instead of data_in (every write beat)
//   do_branch     in   1   flush: aborts an in-flight read
//   busy          out  1   burst in progress; new requests ignored
//   data_out      out  32  read data
//   data_valid    out  1   1-cycle pulse per valid read beat on data_out
//   addr_err      out  1   1-cycle pulse: request rejected
//
// BEHAVIOUR
//   - Reset: busy=0, data_out=0, data_valid=0, addr_err=0, FSM->IDLE, beat counter=0.
//     Memory contents are untouched. Reset wins over every other input.
//   - off = address - BASE_ADDR (32-bit unsigned). A request is legal only if all
//     three hold:
//       1. off + bytes_total - 1 < DEPTH_BYTES (no wrap past the array end);
//       2. alignment: word/burst needs address[1:0]==0, half needs address[0]==0;
//       3. any burst uses dm_size==00.
//     An illegal request pulses addr_err the next cycle, writes nothing, and leaves
//     the FSM in IDLE.
//   - Endianness: byte at off+0 maps to word bits [31:24]; a half at off+0 maps to [31:16].
//   - Sub-word write: data[7:0] or data[15:0] is stored at off. Other bytes are unchanged.
//   - Sub-word read: the byte/half is right-justified in data_out, upper bits sign- or
//     zero-extended per sign_ext.
//   - FSM states:
//       IDLE  -> RBURST on a legal read burst accept; -> WBURST on a legal write burst accept.
//       RBURST: beat i reads word off+4*i. Exits to IDLE after the last beat or on do_branch.
//       WBURST: beat i writes word off+4*i. Exits to IDLE after the last beat.
//   - Single access (access_size==00): busy is never raised.
//       Read: data_out and data_valid=1 in the cycle after accept.
//       Write: committed at the accept edge.
//   - Read burst of N beats:
//       busy=1 from the cycle after accept until the cycle carrying the last beat,
//       then 0 the cycle after.
//       data_valid=1 on N consecutive cycles starting the cycle after accept;
//       beat i appears at accept+1+i.
//   - Write burst of N beats:
//       beat 0 is written at the accept edge; beat i at the i-th following edge
//       (data_in sampled that edge).
//       busy=1 for cycles accept+1 .. accept+N-1.
//   - do_branch while reading (single pending or RBURST): the next data_out=0 with
//     data_valid=0, the burst is aborted, and busy drops the following cycle.
//     do_branch has no effect on writes.
//   - enable while busy=1 is ignored (not queued). enable in the last busy cycle is
//     also ignored.
//   - The beat counter is 4 bits, counts 0..N-1, and never wraps mid-burst. Addresses
//     inside a burst never wrap, guaranteed by the range check.
//
// TESTING
//   1. Write word 32'hDEADBEEF @80020000, read word -> data_out=DEADBEEF, data_valid 1 cycle after accept.
//   2. Read byte @80020001, sign_ext=1 -> FFFFFFAD; sign_ext=0 -> 000000AD; read half @80020002 -> 0000BEEF.
//   3. Write byte 8'h11 @80020003, read word -> DEADBE11; half write @80020001 -> addr_err=1, memory unchanged.
//   4. 4-beat write burst (1,2,3,4) @80020010 then 4-beat read -> 1,2,3,4 on consecutive cycles; busy high 4 cycles.
//   5. 16-beat read, do_branch at beat 5 -> beats 0-4 valid, next data_out=0 with data_valid=0, busy low after; new request accepted.
//   6. Read word @(BASE_ADDR+DEPTH_BYTES-2) and @7FFFFFFC -> addr_err pulse; reset during 8-beat write at beat 3 -> beats 0-2 written, 3-7 not, busy=0.

Source files
------------

// File: rtl/burst_memory.sv
`default_nettype none
// ============================================================================
//  Module   : burst_memory
//  Purpose  : Byte-addressed big-endian unified memory. It supports single
//             word/half/byte accesses with sign or zero extension and
//             4/8/16-beat word bursts, and it rejects out-of-range or
//             misaligned requests.
//  Revision : 1.0 - initial release
// ============================================================================
module burst_memory #(
  parameter int unsigned DEPTH_BYTES = 1048576,
  parameter logic [31:0] BASE_ADDR   = 32'h80020000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        rw_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_in_i,
  input  logic [1:0]  access_size_i,
  input  logic [1:0]  dm_size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wm_bypass_i,
  input  logic        do_wm_bypass_i,
  input  logic        do_branch_i,
  output logic        busy_o,
  output logic [31:0] data_out_o,
  output logic        data_valid_o,
  output logic        addr_err_o
);

  localparam int unsigned WORDS   = DEPTH_BYTES / 4;
  localparam int unsigned AW      = $clog2(WORDS);
  localparam logic [32:0] DEPTH33 = 33'(DEPTH_BYTES);
  localparam logic [AW-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RBURST = 2'd1,
    ST_WBURST = 2'd2
  } state_e;

  // Storage: one 32-bit word per entry, byte lane 3 holds the lowest address.
  logic [31:0] mem_q [WORDS];

  state_e        state_q;
  logic [3:0]    beat_q;
  logic [3:0]    last_q;
  logic [AW-1:0] waddr_q;
  logic          busy_q;
  logic [31:0]   data_out_q;
  logic          data_valid_q;
  logic          addr_err_q;

  // Request decode
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_last;
  logic [6:0]    w_bytes;
  logic [32:0]   w_end;
  logic          w_is_burst;
  logic          w_align_ok;
  logic          w_range_ok;
  logic          w_size_ok;
  logic          w_legal;
  logic          w_accept;
  logic [31:0]   w_wsrc;

  // Memory write port
  logic          w_we;
  logic [AW-1:0] w_widx;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wdata;

  assign w_off      = address_i - BASE_ADDR;
  assign w_idx      = w_off[AW+1:2];
  assign w_is_burst = (access_size_i != 2'b00);
  assign w_wsrc     = do_wm_bypass_i ? wm_bypass_i : data_in_i;
  assign w_accept   = enable_i && (state_q == ST_IDLE);

  // Burst length and total byte span of the request.
  always_comb begin
    w_last  = 4'd0;
    w_bytes = 7'd4;
    case (access_size_i)
      2'b01:   w_last = 4'd3;
      2'b10:   w_last = 4'd7;
      2'b11:   w_last = 4'd15;
      default: w_last = 4'd0;
    endcase
    if (w_is_burst)
      w_bytes = {1'b0, w_last, 2'b00} + 7'd4;
    else if (dm_size_i == 2'b01)
      w_bytes = 7'd2;
    else if (dm_size_i == 2'b10)
      w_bytes = 7'd1;
    else
      w_bytes = 7'd4;
  end

  // Legality: the 33-bit end offset catches both wrap below BASE_ADDR and
  // overrun past the end of the array.
  assign w_end      = {1'b0, w_off} + {26'd0, w_bytes} - 33'd1;
  assign w_range_ok = (w_end < DEPTH33);
  assign w_align_ok = (w_is_burst || dm_size_i == 2'b00 || dm_size_i == 2'b11)
                        ? (address_i[1:0] == 2'b00)
                        : ((dm_size_i == 2'b01) ? !address_i[0] : 1'b1);
  assign w_size_ok  = !w_is_burst || (dm_size_i == 2'b00);
  assign w_legal    = w_range_ok && w_align_ok && w_size_ok;

  // Write port selection; reset suppresses any write on that edge.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_idx;
    w_wmask = 4'b0000;
    w_wdata = w_wsrc;
    if (!reset_i) begin
      if (w_accept && w_legal && !rw_i) begin
        w_we = 1'b1;
        if (w_is_burst) begin
          w_wmask = 4'b1111;
        end else begin
          case (dm_size_i)
            2'b01: begin
              w_wmask = w_off[1] ? 4'b0011 : 4'b1100;
              w_wdata = {2{w_wsrc[15:0]}};
            end
            2'b10: begin
              w_wmask = 4'b1000 >> w_off[1:0];
              w_wdata = {4{w_wsrc[7:0]}};
            end
            default: w_wmask = 4'b1111;
          endcase
        end
      end else if (state_q == ST_WBURST) begin
        w_we    = 1'b1;
        w_widx  = waddr_q + IDX_ONE;
        w_wmask = 4'b1111;
      end
    end
  end

  // Right-justify a byte or half from a big-endian word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  dm,
                                          input logic [1:0]  lane,
                                          input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    case (dm)
      2'b01:   extract = {{16{sext & h[15]}}, h};
      2'b10:   extract = {{24{sext & b[7]}}, b};
      default: extract = word;
    endcase
  endfunction

  // Byte-masked memory write.
  always_ff @(posedge clock_i) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b])
          mem_q[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM with registered read data and status outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      beat_q       <= 4'd0;
      last_q       <= 4'd0;
      waddr_q      <= '0;
      busy_q       <= 1'b0;
      data_out_q   <= 32'd0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            if (!w_legal) begin
              addr_err_q <= 1'b1;
            end else if (rw_i) begin
              if (do_branch_i) begin
                // Flush arrived with the read: squash it entirely.
                data_out_q <= 32'd0;
              end else begin
                data_out_q   <= extract(mem_q[w_idx], dm_size_i, w_off[1:0], sign_ext_i);
                data_valid_q <= 1'b1;
                if (w_is_burst) begin
                  state_q <= ST_RBURST;
                  busy_q  <= 1'b1;
                  beat_q  <= 4'd0;
                  last_q  <= w_last;
                  waddr_q <= w_idx;
                end
              end
            end else if (w_is_burst) begin
              // Beat 0 is committed by the write port on this edge.
              state_q <= ST_WBURST;
              busy_q  <= 1'b1;
              beat_q  <= 4'd0;
              last_q  <= w_last;
              waddr_q <= w_idx;
            end
          end
        end
        ST_RBURST: begin
          if (do_branch_i) begin
            data_out_q <= 32'd0;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
          end else if (beat_q == last_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            data_out_q   <= mem_q[waddr_q + IDX_ONE];
            data_valid_q <= 1'b1;
            beat_q       <= beat_q + 4'd1;
            waddr_q      <= waddr_q + IDX_ONE;
          end
        end
        ST_WBURST: begin
          beat_q  <= beat_q + 4'd1;
          waddr_q <= waddr_q + IDX_ONE;
          if (beat_q + 4'd1 == last_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign addr_err_o   = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_burst_memory
//  Purpose  : Self-checking bench for burst_memory against a byte-level
//             reference model of the memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_burst_memory;

  localparam int unsigned DEPTH = 1048576;
  localparam logic [31:0] BASE  = 32'h80020000;
  localparam int unsigned WIN   = 1024;

  logic        clk = 1'b0;
  logic        rst, en, rw, sext, dowmb, br;
  logic [31:0] addr, din, wmb;
  logic [1:0]  asz, dms;
  logic        busy, dval, aerr;
  logic [31:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mm [int unsigned];
  logic [31:0] bdata [16];
  logic [31:0] last_data;

  burst_memory #(.DEPTH_BYTES(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .enable_i      (en),
    .rw_i          (rw),
    .address_i     (addr),
    .data_in_i     (din),
    .access_size_i (asz),
    .dm_size_i     (dms),
    .sign_ext_i    (sext),
    .wm_bypass_i   (wmb),
    .do_wm_bypass_i(dowmb),
    .do_branch_i   (br),
    .busy_o        (busy),
    .data_out_o    (dout),
    .data_valid_o  (dval),
    .addr_err_o    (aerr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int beats(input logic [1:0] sz);
    case (sz)
      2'b01:   return 4;
      2'b10:   return 8;
      2'b11:   return 16;
      default: return 1;
    endcase
  endfunction

  // Legality from first principles: span fits, alignment, bursts are word-only.
  function automatic bit is_legal(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] dm);
    logic [31:0]     o32;
    longint unsigned off, total;
    bit              word_like;
    o32       = a - BASE;
    off       = longint'(o32);
    word_like = (sz != 0) || (dm == 2'd0) || (dm == 2'd3);
    if (sz != 0)         total = 4 * beats(sz);
    else if (dm == 2'd1) total = 2;
    else if (dm == 2'd2) total = 1;
    else                 total = 4;
    if (off + total > DEPTH) return 0;
    if (word_like && (a % 4 != 0)) return 0;
    if (!word_like && dm == 2'd1 && (a % 2 != 0)) return 0;
    if (sz != 0 && dm != 2'd0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] mread(input int unsigned off, input logic [1:0] dm, input bit sx);
    int v;
    case (dm)
      2'd1: begin
        v = int'(mm[off]) * 256 + int'(mm[off+1]);
        if (sx && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      2'd2: begin
        v = int'(mm[off]);
        if (sx && v >= 128) v = v - 256;
        return 32'(v);
      end
      default: return {mm[off], mm[off+1], mm[off+2], mm[off+3]};
    endcase
  endfunction

  task automatic mwrite_word(input int unsigned off, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mm[off + k] = 8'(w >> (24 - 8*k));
  endtask

  task automatic set_idle();
    en = 0; rw = 1; addr = 0; din = 0; wmb = 0; dowmb = 0;
    br = 0; asz = 0; dms = 0; sext = 0;
  endtask

  task automatic drive_wdata(input logic [31:0] d);
    if ($urandom_range(0, 1) == 1) begin
      dowmb = 1; wmb = d; din = $urandom;
    end else begin
      dowmb = 0; din = d; wmb = $urandom;
    end
  endtask

  task automatic junk_inputs();
    en = 1'($urandom); rw = 1'($urandom); addr = $urandom;
    asz = 2'($urandom); dms = 2'($urandom); sext = 1'($urandom);
  endtask

  task automatic single_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] dm);
    bit lg;
    int unsigned off;
    lg  = is_legal(a, 2'd0, dm);
    off = a - BASE;
    set_idle();
    en = 1; rw = 0; addr = a; dms = dm; drive_wdata(d);
    tick();
    check("sw_err", 32'(aerr), lg ? 32'd0 : 32'd1);
    check("sw_busy", 32'(busy), 32'd0);
    set_idle();
    if (lg) begin
      case (dm)
        2'd1: begin mm[off] = d[15:8]; mm[off+1] = d[7:0]; end
        2'd2: mm[off] = d[7:0];
        default: mwrite_word(off, d);
      endcase
    end
  endtask

  task automatic single_read(input logic [31:0] a, input logic [1:0] dm, input bit sx, input bit flush);
    bit lg;
    int unsigned off;
    lg  = is_legal(a, 2'd0, dm);
    off = a - BASE;
    set_idle();
    en = 1; rw = 1; addr = a; dms = dm; sext = sx; br = flush;
    tick();
    check("sr_err", 32'(aerr), lg ? 32'd0 : 32'd1);
    check("sr_busy", 32'(busy), 32'd0);
    if (!lg) begin
      check("sr_bad_valid", 32'(dval), 32'd0);
    end else if (flush) begin
      check("sr_flush_valid", 32'(dval), 32'd0);
      check("sr_flush_data", dout, 32'd0);
    end else begin
      check("sr_valid", 32'(dval), 32'd1);
      check("sr_data", dout, mread(off, dm, sx));
    end
    last_data = dout;
    set_idle();
  endtask

  task automatic burst_write(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] dm, input int reset_at);
    bit lg;
    int unsigned off;
    int n;
    n   = beats(sz);
    lg  = is_legal(a, sz, dm);
    off = a - BASE;
    set_idle();
    en = 1; rw = 0; addr = a; asz = sz; dms = dm; drive_wdata(bdata[0]);
    tick();
    check("bw_err", 32'(aerr), lg ? 32'd0 : 32'd1);
    if (!lg) begin
      check("bw_bad_busy", 32'(busy), 32'd0);
      set_idle();
      return;
    end
    mwrite_word(off, bdata[0]);
    for (int i = 1; i < n; i++) begin
      check("bw_busy", 32'(busy), 32'd1);
      if (i == reset_at) begin
        set_idle();
        en = 1; rw = 1; addr = BASE;
        rst = 1;
        tick();
        rst = 0;
        check("bw_rst_busy", 32'(busy), 32'd0);
        check("bw_rst_valid", 32'(dval), 32'd0);
        check("bw_rst_data", dout, 32'd0);
        set_idle();
        return;
      end
      junk_inputs();
      br = 1'($urandom);
      drive_wdata(bdata[i]);
      tick();
      mwrite_word(off + 4*i, bdata[i]);
    end
    check("bw_done_busy", 32'(busy), 32'd0);
    set_idle();
  endtask

  task automatic burst_read(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] dm, input int br_at);
    bit lg;
    int unsigned off;
    int n;
    n   = beats(sz);
    lg  = is_legal(a, sz, dm);
    off = a - BASE;
    set_idle();
    en = 1; rw = 1; addr = a; asz = sz; dms = dm;
    tick();
    check("br_err", 32'(aerr), lg ? 32'd0 : 32'd1);
    if (!lg) begin
      check("br_bad_valid", 32'(dval), 32'd0);
      check("br_bad_busy", 32'(busy), 32'd0);
      set_idle();
      return;
    end
    for (int i = 0; i <= n; i++) begin
      if (i == n) begin
        check("br_end_valid", 32'(dval), 32'd0);
        check("br_end_busy", 32'(busy), 32'd0);
        break;
      end
      if (i == br_at) begin
        check("br_flush_valid", 32'(dval), 32'd0);
        check("br_flush_data", dout, 32'd0);
        check("br_flush_busy", 32'(busy), 32'd0);
        break;
      end
      check("br_valid", 32'(dval), 32'd1);
      check("br_data", dout, mread(off + 4*i, 2'd0, 1'b0));
      check("br_busy", 32'(busy), 32'd1);
      junk_inputs();
      din = $urandom; wmb = $urandom; dowmb = 1'($urandom);
      br = (i + 1 == br_at);
      tick();
    end
    set_idle();
  endtask

  initial begin
    logic [31:0] a;
    int unsigned off;
    int          n, k, bat;
    logic [1:0]  sz, dm;

    set_idle();
    rst = 1;
    en = 1; rw = 1; addr = BASE;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", dout, 32'd0);
    check("rst_valid", 32'(dval), 32'd0);
    check("rst_err", 32'(aerr), 32'd0);
    set_idle();
    rst = 0;
    tick();

    // Fill the test window with known random words.
    for (int b = 0; b < WIN / 64; b++) begin
      for (int i = 0; i < 16; i++) bdata[i] = $urandom;
      burst_write(BASE + 32'(64 * b), 2'b11, 2'b00, -1);
    end

    // Word write / read and sub-word reads.
    single_write(BASE, 32'hDEADBEEF, 2'd0);
    single_read(BASE, 2'd0, 1'b0, 1'b0);
    check("t1_word", last_data, 32'hDEADBEEF);
    single_read(BASE + 1, 2'd2, 1'b1, 1'b0);
    check("t2_byte_sext", last_data, 32'hFFFFFFAD);
    single_read(BASE + 1, 2'd2, 1'b0, 1'b0);
    check("t2_byte_zext", last_data, 32'h000000AD);
    single_read(BASE + 2, 2'd1, 1'b0, 1'b0);
    check("t2_half", last_data, 32'h0000BEEF);

    // Byte write, then a misaligned half write that must be rejected.
    single_write(BASE + 3, 32'h00000011, 2'd2);
    single_read(BASE, 2'd0, 1'b0, 1'b0);
    check("t3_byte_wr", last_data, 32'hDEADBE11);
    single_write(BASE + 1, 32'h00007777, 2'd1);
    single_read(BASE, 2'd0, 1'b0, 1'b0);
    check("t3_unchanged", last_data, 32'hDEADBE11);

    // 4-beat write then read back.
    bdata[0] = 1; bdata[1] = 2; bdata[2] = 3; bdata[3] = 4;
    burst_write(BASE + 32'h10, 2'b01, 2'b00, -1);
    burst_read(BASE + 32'h10, 2'b01, 2'b00, -1);

    // 16-beat read flushed after five beats, then a fresh request.
    burst_read(BASE + 32'h40, 2'b11, 2'b00, 5);
    single_read(BASE + 32'h10, 2'd0, 1'b0, 1'b0);
    check("t5_after_flush", last_data, 32'd1);

    // Range errors and the legal top-of-array word.
    single_read(BASE + DEPTH - 2, 2'd0, 1'b0, 1'b0);
    single_read(32'h7FFFFFFC, 2'd0, 1'b0, 1'b0);
    burst_read(BASE + DEPTH - 60, 2'b11, 2'b00, -1);
    burst_read(BASE + 32'h20, 2'b01, 2'b10, -1);
    single_write(BASE + DEPTH - 4, 32'hA5C3_0F96, 2'd0);
    single_read(BASE + DEPTH - 4, 2'd0, 1'b0, 1'b0);
    single_read(BASE + DEPTH - 1, 2'd2, 1'b1, 1'b0);

    // Reset during an 8-beat write: only beats 0-2 land.
    for (int i = 0; i < 8; i++) bdata[i] = 32'hC0DE0000 + 32'(i);
    burst_write(BASE + 32'h100, 2'b10, 2'b00, 3);
    burst_read(BASE + 32'h100, 2'b10, 2'b00, -1);

    // A write presented during reset must not land.
    set_idle();
    en = 1; rw = 0; addr = BASE + 32'h20; din = 32'hCAFEF00D;
    rst = 1;
    tick();
    rst = 0;
    set_idle();
    single_read(BASE + 32'h20, 2'd0, 1'b0, 1'b0);

    // Randomised traffic against the model.
    for (int it = 0; it < 150; it++) begin
      k  = $urandom_range(0, 9);
      dm = 2'($urandom);
      case (k)
        0, 1, 2: begin
          off = $urandom_range(0, WIN - 4);
          if ($urandom_range(0, 4) != 0) off = (dm == 2'd1) ? (off & ~32'd1) : (dm == 2'd2) ? off : (off & ~32'd3);
          single_write(BASE + off, $urandom, dm);
        end
        3, 4, 5, 9: begin
          off = $urandom_range(0, WIN - 4);
          if ($urandom_range(0, 4) != 0) off = (dm == 2'd1) ? (off & ~32'd1) : (dm == 2'd2) ? off : (off & ~32'd3);
          single_read(BASE + off, dm, 1'($urandom), $urandom_range(0, 7) == 0);
        end
        6, 7: begin
          sz  = 2'($urandom_range(1, 3));
          n   = beats(sz);
          off = $urandom_range(0, WIN - 4 * n);
          if ($urandom_range(0, 5) != 0) off = off & ~32'd3;
          if ($urandom_range(0, 5) != 0) dm = 2'd0;
          if (k == 6) begin
            for (int i = 0; i < 16; i++) bdata[i] = $urandom;
            burst_write(BASE + off, sz, dm, -1);
          end else begin
            bat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
            burst_read(BASE + off, sz, dm, bat);
          end
        end
        default: begin
          case ($urandom_range(0, 3))
            0: single_read(BASE + DEPTH - 2, 2'd0, 1'b0, 1'b0);
            1: single_read(BASE - 4, 2'd0, 1'b0, 1'b0);
            2: burst_read(BASE + DEPTH - 16, 2'b10, 2'b00, -1);
            default: single_write(32'h00000000, $urandom, 2'd0);
          endcase
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
